// File: rtl/ddfs_pkg.sv
// Shared constants and types for the DDFS sine engine.
// Defaults cover a 30-bit accumulator, 256-entry quarter-wave ROM and 16-bit PCM.
package ddfs_pkg;

  localparam int PW_DEF     = 30;
  localparam int LUT_AW_DEF = 8;
  localparam int DW_DEF     = 16;

  localparam logic signed [15:0] ENV_ONE = 16'sh4000;

  localparam int SAT_MAX = 2 ** (DW_DEF - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DW_DEF - 1));

  // Top two phase bits: odd quadrants read the ROM mirrored, upper half is negated.
  typedef enum logic [1:0] {
    Q_RISE_POS = 2'd0,
    Q_FALL_POS = 2'd1,
    Q_RISE_NEG = 2'd2,
    Q_FALL_NEG = 2'd3
  } quadrant_t;

endpackage

// File: rtl/ddfs_sin_rom.sv
// Quarter-wave sine ROM, 15-bit unsigned magnitude, one-cycle synchronous read.
// Entries are round(32767*sin((i+0.5)*pi/(2*DEPTH))), built at elaboration.
module ddfs_sin_rom #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [14:0]   data
);

  localparam int DEPTH = 2 ** AW;

  // Taylor series to x^19; x never exceeds pi/2 so the error is far below one LSB.
  function automatic logic [14:0] sin_entry(input int i);
    real x;
    real term;
    real acc;
    x    = (real'(i) + 0.5) * 3.14159265358979 / (2.0 * real'(DEPTH));
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return 15'($rtoi(acc * 32767.0 + 0.5));
  endfunction

  logic [14:0] rom_tbl [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam logic [14:0] ENTRY = sin_entry(gi);
    assign rom_tbl[gi] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data <= rom_tbl[addr];
  end

endmodule

// File: rtl/ddfs_core.sv
// Four-stage DDFS: phase accumulate, quarter-wave ROM lookup, sign, envelope scale.
// One signed PCM sample per sample_tick, pcm_valid four cycles after the tick.
module ddfs_core
  import ddfs_pkg::*;
#(
  parameter int PW     = PW_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PW-1:0]        fccw,
  input  logic [PW-1:0]        focw,
  input  logic [PW-1:0]        pha,
  input  logic signed [15:0]   env,
  input  logic                 phase_clr,
  input  logic                 sample_tick,
  output logic signed [DW-1:0] pcm_out,
  output logic                 pcm_valid
);

  logic [PW-1:0]        p_reg;
  logic [PW-1:0]        p_base;
  logic [PW-1:0]        ph_sum;
  logic [LUT_AW+1:0]    ph_s1;
  logic signed [15:0]   env_s1;
  logic signed [15:0]   env_s2;
  logic signed [15:0]   env_s3;
  logic                 v_s1;
  logic                 v_s2;
  logic                 v_s3;
  quadrant_t            q_s1;
  logic                 mirror_s1;
  logic                 neg_s1;
  logic                 neg_s2;
  logic [LUT_AW-1:0]    a_s1;
  logic [LUT_AW-1:0]    rom_addr;
  logic [14:0]          rom_data;
  logic signed [15:0]   val_s3;
  logic signed [31:0]   prod;
  logic signed [31:0]   prod_sh;
  logic signed [DW-1:0] pcm_sat;
  logic                 unused_lsb;

  // A phase clear makes the accumulator read as zero for this cycle's sample.
  assign p_base     = phase_clr ? '0 : p_reg;
  assign ph_sum     = p_base + pha;
  assign unused_lsb = ^ph_sum[PW-3-LUT_AW:0];

  assign q_s1      = quadrant_t'(ph_s1[LUT_AW+1:LUT_AW]);
  assign a_s1      = ph_s1[LUT_AW-1:0];
  assign mirror_s1 = (q_s1 == Q_FALL_POS) || (q_s1 == Q_FALL_NEG);
  assign neg_s1    = (q_s1 == Q_RISE_NEG) || (q_s1 == Q_FALL_NEG);
  assign rom_addr  = mirror_s1 ? ~a_s1 : a_s1;

  ddfs_sin_rom #(.AW(LUT_AW)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign prod    = val_s3 * env_s3;
  assign prod_sh = prod >>> 14;

  always_comb begin
    pcm_sat = prod_sh[DW-1:0];
    if (prod_sh > SAT_MAX) begin
      pcm_sat = DW'(SAT_MAX);
    end else if (prod_sh < SAT_MIN) begin
      pcm_sat = DW'(SAT_MIN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg     <= '0;
      v_s1      <= 1'b0;
      v_s2      <= 1'b0;
      v_s3      <= 1'b0;
      pcm_valid <= 1'b0;
      pcm_out   <= '0;
    end else begin
      if (sample_tick) begin
        p_reg <= p_base + fccw + focw;
      end else if (phase_clr) begin
        p_reg <= '0;
      end
      v_s1      <= sample_tick;
      v_s2      <= v_s1;
      v_s3      <= v_s2;
      pcm_valid <= v_s3;
      if (v_s3) begin
        pcm_out <= pcm_sat;
      end
    end
  end

  // Datapath needs no reset: the valid chain above gates every use of it.
  always_ff @(posedge clk) begin
    if (sample_tick) begin
      ph_s1  <= ph_sum[PW-1 -: LUT_AW+2];
      env_s1 <= env;
    end
    neg_s2 <= neg_s1;
    env_s2 <= env_s1;
    val_s3 <= neg_s2 ? -$signed({1'b0, rom_data}) : $signed({1'b0, rom_data});
    env_s3 <= env_s2;
  end

endmodule
